reg_bank_shadowed: RTL



---
 rtl/reg_bank_pkg.sv | 37 +++
 rtl/reg_bank_addr_dec.sv | 51 +++++
 rtl/reg_bank_shadowed.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// ============================================================================
// reg_bank_pkg : shared constants and types for the shadowed register bank
// Rev 1.0
// ============================================================================
`default_nettype none

package reg_bank_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;

    localparam logic [15:0] DEF_CFG_BASE = 16'h0001;
    localparam logic [15:0] DEF_STS_BASE = 16'h0040;
    localparam logic [15:0] DEF_EVT_ADDR = 16'h0060;
    localparam logic [15:0] DEF_CMD_ADDR = 16'h0080;

    localparam int unsigned CMD_START  = 0;
    localparam int unsigned CMD_ABORT  = 1;
    localparam int unsigned EVT_REJECT = 15;

    typedef enum logic [2:0] {
        REG_CFG  = 3'd0,
        REG_STS  = 3'd1,
        REG_EVT  = 3'd2,
        REG_MASK = 3'd3,
        REG_CMD  = 3'd4,
        REG_NONE = 3'd5
    } reg_region_e;

    // Index width able to address n words, never less than one bit.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_bank_addr_dec.sv
// ============================================================================
// reg_bank_addr_dec : combinational bus address to {region, word index} decode
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_bank_addr_dec
    import reg_bank_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       NUM_CFG  = 16,
    parameter int unsigned       NUM_STS  = 4,
    parameter int unsigned       IDX_W    = 4,
    parameter logic [ADDR_W-1:0] CFG_BASE = ADDR_W'(DEF_CFG_BASE),
    parameter logic [ADDR_W-1:0] STS_BASE = ADDR_W'(DEF_STS_BASE),
    parameter logic [ADDR_W-1:0] EVT_ADDR = ADDR_W'(DEF_EVT_ADDR),
    parameter logic [ADDR_W-1:0] CMD_ADDR = ADDR_W'(DEF_CMD_ADDR)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output reg_region_e       region_o,
    output logic [IDX_W-1:0]  index_o
);

    logic [ADDR_W-1:0] w_cfg_off;
    logic [ADDR_W-1:0] w_sts_off;

    // Offsets wrap below the base, so a single unsigned compare bounds each window.
    assign w_cfg_off = addr_i - CFG_BASE;
    assign w_sts_off = addr_i - STS_BASE;

    always_comb begin
        region_o = REG_NONE;
        index_o  = '0;
        if (w_cfg_off < ADDR_W'(NUM_CFG)) begin
            region_o = REG_CFG;
            index_o  = w_cfg_off[IDX_W-1:0];
        end else if (w_sts_off < ADDR_W'(NUM_STS)) begin
            region_o = REG_STS;
            index_o  = w_sts_off[IDX_W-1:0];
        end else if (addr_i == EVT_ADDR) begin
            region_o = REG_EVT;
        end else if (addr_i == EVT_ADDR + ADDR_W'(1)) begin
            region_o = REG_MASK;
        end else if (addr_i == CMD_ADDR) begin
            region_o = REG_CMD;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_bank_shadowed.sv
// ============================================================================
// reg_bank_shadowed : bus register bank with shadow/active config, status,
//                     sticky events with irq mask and pulsed commands
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_bank_shadowed
    import reg_bank_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter int unsigned       NUM_CFG  = 16,
    parameter int unsigned       NUM_STS  = 4,
    parameter logic [ADDR_W-1:0] CFG_BASE = ADDR_W'(DEF_CFG_BASE),
    parameter logic [ADDR_W-1:0] STS_BASE = ADDR_W'(DEF_STS_BASE),
    parameter logic [ADDR_W-1:0] EVT_ADDR = ADDR_W'(DEF_EVT_ADDR),
    parameter logic [ADDR_W-1:0] CMD_ADDR = ADDR_W'(DEF_CMD_ADDR)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bus_wr,
    input  logic                        bus_rd,
    input  logic [ADDR_W-1:0]           bus_addr,
    input  logic [DATA_W-1:0]           bus_wdata,
    output logic [DATA_W-1:0]           bus_rdata,
    output logic                        bus_rvalid,
    output logic                        bus_err,
    output logic [NUM_CFG*DATA_W-1:0]   cfg_active,
    output logic                        cfg_update,
    output logic [DATA_W-1:0]           cmd_pulse,
    input  logic                        core_busy,
    input  logic [NUM_STS*DATA_W-1:0]   sts_live,
    input  logic [DATA_W-1:0]           evt_set,
    output logic                        evt_irq
);

    localparam int unsigned CFG_IW = idx_bits(NUM_CFG);
    localparam int unsigned STS_IW = idx_bits(NUM_STS);
    localparam int unsigned IDX_W  = (CFG_IW > STS_IW) ? CFG_IW : STS_IW;

    reg_region_e      w_region;
    logic [IDX_W-1:0] w_idx;
    logic [DATA_W-1:0] w_sts [NUM_STS];

    logic [DATA_W-1:0] shadow_q [NUM_CFG];
    logic [DATA_W-1:0] active_q [NUM_CFG];
    logic [DATA_W-1:0] evt_q, evt_d;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] cmd_pulse_q, cmd_pulse_d;
    logic              rvalid_q, err_q, err_d, update_q, irq_q;
    logic              w_cmd_wr, w_start_ok, w_reject;

    reg_bank_addr_dec #(
        .ADDR_W  (ADDR_W),
        .NUM_CFG (NUM_CFG),
        .NUM_STS (NUM_STS),
        .IDX_W   (IDX_W),
        .CFG_BASE(CFG_BASE),
        .STS_BASE(STS_BASE),
        .EVT_ADDR(EVT_ADDR),
        .CMD_ADDR(CMD_ADDR)
    ) u_dec (
        .addr_i  (bus_addr),
        .region_o(w_region),
        .index_o (w_idx)
    );

    for (genvar s = 0; s < NUM_STS; s++) begin : g_sts
        assign w_sts[s] = sts_live[s*DATA_W +: DATA_W];
    end

    for (genvar c = 0; c < NUM_CFG; c++) begin : g_cfg_out
        assign cfg_active[c*DATA_W +: DATA_W] = active_q[c];
    end

    assign w_cmd_wr   = bus_wr && (w_region == REG_CMD);
    assign w_start_ok = w_cmd_wr && bus_wdata[CMD_START] && !core_busy;
    assign w_reject   = w_cmd_wr && bus_wdata[CMD_START] && core_busy;

    always_comb begin
        cmd_pulse_d = '0;
        if (w_cmd_wr) begin
            cmd_pulse_d            = bus_wdata;
            cmd_pulse_d[CMD_START] = w_start_ok;
        end

        // Clear first, then OR in sets so a same-cycle set always wins.
        evt_d = evt_q;
        if (bus_wr && (w_region == REG_EVT)) begin
            evt_d = evt_q & ~bus_wdata;
        end
        evt_d = evt_d | evt_set;
        if (w_reject) begin
            evt_d[EVT_REJECT] = 1'b1;
        end

        rdata_d = '0;
        if (bus_rd) begin
            case (w_region)
                REG_CFG:  rdata_d = shadow_q[w_idx[CFG_IW-1:0]];
                REG_STS:  rdata_d = w_sts[w_idx[STS_IW-1:0]];
                REG_EVT:  rdata_d = evt_q;
                REG_MASK: rdata_d = mask_q;
                default:  rdata_d = '0;
            endcase
        end

        err_d = (bus_rd || bus_wr) && (w_region == REG_NONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            evt_q       <= '0;
            mask_q      <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            cmd_pulse_q <= '0;
            update_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (bus_wr && (w_region == REG_CFG)) begin
                shadow_q[w_idx[CFG_IW-1:0]] <= bus_wdata;
            end
            if (w_start_ok) begin
                for (int i = 0; i < NUM_CFG; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (bus_wr && (w_region == REG_MASK)) begin
                mask_q <= bus_wdata;
            end
            evt_q       <= evt_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= bus_rd;
            err_q       <= err_d;
            cmd_pulse_q <= cmd_pulse_d;
            update_q    <= w_start_ok;
            irq_q       <= |(evt_q & mask_q);
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;
    assign bus_err    = err_q;
    assign evt_irq    = irq_q;
    // A reset arriving while a pulse is pending suppresses it immediately.
    assign cmd_pulse  = rst ? '0 : cmd_pulse_q;
    assign cfg_update = update_q & ~rst;

endmodule

`default_nettype wire
